// File: rtl/q313_div_seq.sv
// q313_div_seq: sequential signed Q3.13 restoring divider, res = sat((num << 13) / den).
// Define Q313_DIV_ROUND_EN for round-half-away-from-zero instead of truncation.
module q313_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] num,
  input  logic [15:0] den,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] res,
  output logic        div_by_zero,
  output logic        sat
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic sign, zero, accept, rnd, fix_sat;
  logic [28:0] dvd, q;
  logic [15:0] dvs, num_mag, den_mag, fix_res;
  logic [16:0] rem, rem_sh;
  logic [17:0] diff;
  logic [29:0] qr;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // A zero divisor skips CALC but still passes through FIX, giving a one-edge latency.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (den == 16'd0) ? FIX : CALC;
      CALC: if (cnt == 5'd28) state_nx = FIX;
      FIX: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  assign accept = in_valid && in_ready;
  assign num_mag = num[15] ? -num : num;
  assign den_mag = den[15] ? -den : den;
  assign rem_sh = {rem[15:0], dvd[28]};
  assign diff = {1'b0, rem_sh} - {2'b00, dvs};
`ifdef Q313_DIV_ROUND_EN
  assign rnd = {rem, 1'b0} >= {2'b00, dvs};
`else
  assign rnd = 1'b0;
`endif
  assign qr = {1'b0, q} + {29'd0, rnd};
  assign fix_sat = zero || (sign ? qr > 30'd32768 : qr > 30'd32767);
  assign fix_res = fix_sat ? (sign ? 16'h8000 : 16'h7FFF) : (sign ? -qr[15:0] : qr[15:0]);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 5'd0;
      sign <= 1'b0;
      zero <= 1'b0;
      dvd <= 29'd0;
      dvs <= 16'd0;
      rem <= 17'd0;
      q <= 29'd0;
      res <= 16'd0;
      div_by_zero <= 1'b0;
      sat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign <= num[15] ^ den[15];
          zero <= den == 16'd0;
          dvd <= {num_mag, 13'd0};
          dvs <= den_mag;
          rem <= 17'd0;
          q <= 29'd0;
          cnt <= 5'd0;
        end
        CALC: begin
          rem <= diff[17] ? rem_sh : diff[16:0];
          q <= {q[27:0], ~diff[17]};
          dvd <= dvd << 1;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          res <= fix_res;
          sat <= fix_sat;
          div_by_zero <= zero;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_q313_div_seq.sv
// tb_q313_div_seq: directed and random checks of q313_div_seq against an arithmetic model.
module tb_q313_div_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] num = 16'd0, den = 16'd0;
  logic in_ready, out_valid, div_by_zero, sat;
  logic [15:0] res;
  int checks = 0, passes = 0;

  q313_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .den(den), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .div_by_zero(div_by_zero), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Returns {div_by_zero, sat, res} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] n, input logic [15:0] d);
    int ni, di;
    longint a, b, q, r, v;
    ni = int'($signed(n));
    di = int'($signed(d));
    if (di == 0) return {2'b11, (ni < 0) ? 16'h8000 : 16'h7FFF};
    a = longint'(ni < 0 ? -ni : ni) * 8192;
    b = longint'(di < 0 ? -di : di);
    q = a / b;
    r = a % b;
`ifdef Q313_DIV_ROUND_EN
    if (2 * r >= b) q++;
`endif
    v = ((ni < 0) != (di < 0)) ? -q : q;
    if (v > 32767) return {2'b01, 16'h7FFF};
    if (v < -32768) return {2'b01, 16'h8000};
    return {2'b00, 16'(v)};
  endfunction

  task automatic run(input string tag, input logic [15:0] n, input logic [15:0] d,
                     input int hold, input int want);
    logic [17:0] e;
    int edges;
    e = model(n, d);
    edges = 0;
    while (!in_ready && edges < 100) begin
      step;
      edges++;
    end
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    num = n;
    den = d;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    num = 16'($urandom);
    den = 16'($urandom);
    edges = 0;
    while (!out_valid && edges < 100) begin
      step;
      edges++;
    end
    chk({tag, " latency"}, edges, (d == 16'd0) ? 32'd1 : 32'd30);
    chk({tag, " res"}, {16'd0, res}, {16'd0, e[15:0]});
    chk({tag, " flags"}, {30'd0, div_by_zero, sat}, {30'd0, e[17:16]});
    if (want >= 0) chk({tag, " spec"}, {16'd0, res}, want);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      num = 16'($urandom);
      den = 16'($urandom);
      step;
      chk({tag, " hold"}, {12'd0, out_valid, in_ready, div_by_zero, sat, res},
          {12'd0, 2'b10, e[17:16], e[15:0]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk({tag, " xfer"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic seen;
    step;
    step;
    chk("reset", {12'd0, in_ready, out_valid, div_by_zero, sat, res}, {12'd0, 4'b1000, 16'd0});
    rst = 1'b0;
    run("2/1", 16'h4000, 16'h2000, 0, 'h4000);
    run("-1/2", 16'hE000, 16'h4000, 0, 'hF000);
`ifdef Q313_DIV_ROUND_EN
    run("1/3", 16'h2000, 16'h6000, 0, 'h0AAB);
    run("-1/3", 16'hE000, 16'h6000, 0, 'hF555);
`else
    run("1/3", 16'h2000, 16'h6000, 0, 'h0AAA);
    run("-1/3", 16'hE000, 16'h6000, 0, 'hF556);
`endif
    run("max/eps", 16'h7FFF, 16'h0001, 0, 'h7FFF);
    run("min/eps", 16'h8000, 16'h0001, 0, 'h8000);
    run("min/-eps", 16'h8000, 16'hFFFF, 0, 'h7FFF);
    run("min/1", 16'h8000, 16'h2000, 0, 'h8000);
    run("0/-1", 16'h0000, 16'hE000, 0, 'h0000);
    run("dz pos", 16'h1234, 16'h0000, 0, 'h7FFF);
    run("dz neg", 16'h9000, 16'h0000, 0, 'h8000);
    run("dz zero", 16'h0000, 16'h0000, 0, 'h7FFF);
    run("backpressure", 16'h4000, 16'h2000, 10, 'h4000);
    run("after bp", 16'h1000, 16'h2000, 0, 'h1000);
    num = 16'h4000;
    den = 16'h2000;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (14) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid reset", {12'd0, in_ready, out_valid, div_by_zero, sat, res}, {12'd0, 4'b1000, 16'd0});
    seen = 1'b0;
    repeat (35) begin
      step;
      seen = seen | out_valid;
    end
    chk("discarded op", {31'd0, seen}, 32'd0);
    run("1/1", 16'h2000, 16'h2000, 0, 'h2000);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] n, d;
      n = (i % 7 == 3) ? 16'h8000 : 16'($urandom);
      d = (i % 8 == 0) ? 16'd0 : (i % 5 == 1) ? 16'($urandom_range(1, 7)) : 16'($urandom);
      run("random", n, d, $urandom_range(0, 3), -1);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
